// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback arbiter slice.
package regfile_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 3'd0;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves just past the winner and holds when nothing is requested.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   ptr_nxt_s;
  logic [NREQ-1:0] grant_s;
  logic            found_s;
  int              idx_s;

  // Search from the pointer for the first valid requester.
  always_comb begin
    grant_s   = '0;
    ptr_nxt_s = ptr_r;
    found_s   = 1'b0;
    idx_s     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr_r) + k) % NREQ;
      if (!found_s && req[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        found_s        = 1'b1;
        ptr_nxt_s      = PW'((idx_s + 1) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign grant = grant_s;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port with busy scoreboard.
// Optional same-cycle read bypass registers under `REGFILE_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic                   rf_wen,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic                   sb_set,
  input  logic [ADDR_W-1:0]      sb_addr,
  output logic [(1<<ADDR_W)-1:0] busy,
  input  logic [ADDR_W-1:0]      rd_addr0,
  input  logic [ADDR_W-1:0]      rd_addr1,
  output logic                   byp_hit0,
  output logic                   byp_hit1,
  output logic [DATA_W-1:0]      byp_data0,
  output logic [DATA_W-1:0]      byp_data1
);
  localparam int NR = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NREQ-1:0]   grant_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              wr_ok_s;
  logic              rf_wen_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic [NR-1:0]     busy_r;
  logic [NR-1:0]     busy_nxt_s;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .grant (grant_s)
  );

  // One-hot grant selects the winning address/data.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        sel_addr_s = sel_addr_s | req_addr[i*ADDR_W +: ADDR_W];
        sel_data_s = sel_data_s | req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
    wr_ok_s = (|grant_s) && (sel_addr_s != ZERO_ADDR);
  end

  // Registered write port; r0 writes handshake but never assert rf_wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= '0;
      rf_wdata_r <= '0;
    end else begin
      rf_wen_r <= wr_ok_s;
      if (wr_ok_s) begin
        rf_waddr_r <= sel_addr_s;
        rf_wdata_r <= sel_data_s;
      end
    end
  end

  // Scoreboard next state: the clear is applied first so a same-cycle reservation wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (rf_wen_r) begin
      busy_nxt_s[rf_waddr_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (sb_set && (sb_addr != ZERO_ADDR)) begin
      busy_nxt_s[sb_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic              byp_hit0_r;
  logic              byp_hit1_r;
  logic [DATA_W-1:0] byp_data0_r;
  logic [DATA_W-1:0] byp_data1_r;

  // Capture the in-flight write that a synchronous regfile read would miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_hit0_r  <= 1'b0;
      byp_hit1_r  <= 1'b0;
      byp_data0_r <= '0;
      byp_data1_r <= '0;
    end else begin
      byp_hit0_r  <= rf_wen_r && (rf_waddr_r == rd_addr0) && (rd_addr0 != ZERO_ADDR);
      byp_hit1_r  <= rf_wen_r && (rf_waddr_r == rd_addr1) && (rd_addr1 != ZERO_ADDR);
      byp_data0_r <= rf_wdata_r;
      byp_data1_r <= rf_wdata_r;
    end
  end

  assign byp_hit0  = byp_hit0_r;
  assign byp_hit1  = byp_hit1_r;
  assign byp_data0 = byp_data0_r;
  assign byp_data1 = byp_data1_r;
`else
  logic unused_s;
  assign unused_s  = ^{rd_addr0, rd_addr1};
  assign byp_hit0  = 1'b0;
  assign byp_hit1  = 1'b0;
  assign byp_data0 = '0;
  assign byp_data1 = '0;
`endif

  assign req_ready = grant_s;
  assign rf_wen    = rf_wen_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign busy      = busy_r;
endmodule
